// File: rtl/ahblite_busmatrix_outputstage.sv
// AHB-Lite bus matrix slave-side output stage: arbitrates three decoder ports onto one slave.
// Optional macro OUTPUTSTAGE_RR_ARB_EN selects round-robin arbitration instead of fixed priority.
module ahblite_busmatrix_outputstage #(
    parameter int unsigned HOLD_BURST = 1
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL_P0,
    input  logic        HSEL_P1,
    input  logic        HSEL_P2,
    input  logic [31:0] HADDR_P0,
    input  logic [31:0] HADDR_P1,
    input  logic [31:0] HADDR_P2,
    input  logic [1:0]  HTRANS_P0,
    input  logic [1:0]  HTRANS_P1,
    input  logic [1:0]  HTRANS_P2,
    input  logic        HWRITE_P0,
    input  logic        HWRITE_P1,
    input  logic        HWRITE_P2,
    input  logic [2:0]  HSIZE_P0,
    input  logic [2:0]  HSIZE_P1,
    input  logic [2:0]  HSIZE_P2,
    input  logic [2:0]  HBURST_P0,
    input  logic [2:0]  HBURST_P1,
    input  logic [2:0]  HBURST_P2,
    input  logic [3:0]  HPROT_P0,
    input  logic [3:0]  HPROT_P1,
    input  logic [3:0]  HPROT_P2,
    input  logic [31:0] HWDATA_P0,
    input  logic [31:0] HWDATA_P1,
    input  logic [31:0] HWDATA_P2,
    output logic        ACTIVE_P0,
    output logic        ACTIVE_P1,
    output logic        ACTIVE_P2,
    output logic        HREADYOUT_P0,
    output logic        HREADYOUT_P1,
    output logic        HREADYOUT_P2,
    output logic [1:0]  HRESP_P0,
    output logic [1:0]  HRESP_P1,
    output logic [1:0]  HRESP_P2,
    output logic [31:0] HRDATA_P0,
    output logic [31:0] HRDATA_P1,
    output logic [31:0] HRDATA_P2,
    output logic        HSEL_O,
    output logic [31:0] HADDR_O,
    output logic [1:0]  HTRANS_O,
    output logic        HWRITE_O,
    output logic [2:0]  HSIZE_O,
    output logic [2:0]  HBURST_O,
    output logic [3:0]  HPROT_O,
    output logic [31:0] HWDATA_O,
    output logic        HREADY_O,
    input  logic        HREADYOUT_S,
    input  logic [1:0]  HRESP_S,
    input  logic [31:0] HRDATA_S
);
    localparam int unsigned NP = 3;
    localparam logic [1:0] SEL_NONE = 2'd3;
    localparam logic [1:0] TR_IDLE  = 2'b00;
    localparam logic [1:0] TR_BUSY  = 2'b01;
    localparam logic [1:0] TR_SEQ   = 2'b11;
    localparam logic [1:0] RESP_OK  = 2'b00;

    logic        hsel   [NP];
    logic [31:0] haddr  [NP];
    logic [1:0]  htrans [NP];
    logic        hwrite [NP];
    logic [2:0]  hsize  [NP];
    logic [2:0]  hburst [NP];
    logic [3:0]  hprot  [NP];
    logic [31:0] hwdata [NP];
    logic [NP-1:0] req;

    logic [1:0] addr_sel_q, data_sel_q, addr_sel, arb_pick, arb_next;
    logic       hold;
`ifdef OUTPUTSTAGE_RR_ARB_EN
    logic [1:0] rr_ptr;
`endif

    assign hsel   = '{HSEL_P0, HSEL_P1, HSEL_P2};
    assign haddr  = '{HADDR_P0, HADDR_P1, HADDR_P2};
    assign htrans = '{HTRANS_P0, HTRANS_P1, HTRANS_P2};
    assign hwrite = '{HWRITE_P0, HWRITE_P1, HWRITE_P2};
    assign hsize  = '{HSIZE_P0, HSIZE_P1, HSIZE_P2};
    assign hburst = '{HBURST_P0, HBURST_P1, HBURST_P2};
    assign hprot  = '{HPROT_P0, HPROT_P1, HPROT_P2};
    assign hwdata = '{HWDATA_P0, HWDATA_P1, HWDATA_P2};

    always_comb begin
        for (int i = 0; i < int'(NP); i++) req[i] = hsel[i] & htrans[i][1];
    end

    // Registered owner keeps the slave while it continues a burst (SEQ/BUSY)
    always_comb begin
        hold = 1'b0;
        if (HOLD_BURST != 0 && addr_sel_q != SEL_NONE) begin
            hold = hsel[addr_sel_q] &&
                   (htrans[addr_sel_q] == TR_SEQ || htrans[addr_sel_q] == TR_BUSY);
        end
    end

    always_comb begin
        arb_pick = SEL_NONE;
`ifdef OUTPUTSTAGE_RR_ARB_EN
        // Walk downward so the candidate closest to rr_ptr is the last one written
        for (int k = int'(NP) - 1; k >= 0; k--) begin
            if (req[2'((32'(rr_ptr) + 32'(k)) % 32'(NP))])
                arb_pick = 2'((32'(rr_ptr) + 32'(k)) % 32'(NP));
        end
`else
        if (req[0])      arb_pick = 2'd0;
        else if (req[1]) arb_pick = 2'd1;
        else if (req[2]) arb_pick = 2'd2;
`endif
        arb_next = hold ? addr_sel_q : arb_pick;
    end

    assign addr_sel = HRESET ? SEL_NONE : (HREADYOUT_S ? arb_next : addr_sel_q);

    // Address-phase mux toward the slave
    always_comb begin
        HSEL_O   = 1'b0;
        HADDR_O  = '0;
        HTRANS_O = TR_IDLE;
        HWRITE_O = 1'b0;
        HSIZE_O  = '0;
        HBURST_O = '0;
        HPROT_O  = '0;
        if (addr_sel != SEL_NONE) begin
            HSEL_O   = hsel[addr_sel];
            HADDR_O  = haddr[addr_sel];
            HTRANS_O = htrans[addr_sel];
            HWRITE_O = hwrite[addr_sel];
            HSIZE_O  = hsize[addr_sel];
            HBURST_O = hburst[addr_sel];
            HPROT_O  = hprot[addr_sel];
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            addr_sel_q <= SEL_NONE;
            data_sel_q <= SEL_NONE;
`ifdef OUTPUTSTAGE_RR_ARB_EN
            rr_ptr     <= 2'd0;
`endif
        end else begin
            addr_sel_q <= addr_sel;
            if (HREADYOUT_S) begin
                data_sel_q <= HTRANS_O[1] ? addr_sel : SEL_NONE;
`ifdef OUTPUTSTAGE_RR_ARB_EN
                if (!hold && arb_pick != SEL_NONE)
                    rr_ptr <= (arb_pick == 2'd2) ? 2'd0 : arb_pick + 2'd1;
`endif
            end
        end
    end

    assign HWDATA_O = (data_sel_q != SEL_NONE) ? hwdata[data_sel_q] : 32'd0;
    assign HREADY_O = HREADYOUT_S;

    assign ACTIVE_P0 = (addr_sel == 2'd0);
    assign ACTIVE_P1 = (addr_sel == 2'd1);
    assign ACTIVE_P2 = (addr_sel == 2'd2);

    assign HREADYOUT_P0 = (data_sel_q == 2'd0) ? HREADYOUT_S : 1'b1;
    assign HREADYOUT_P1 = (data_sel_q == 2'd1) ? HREADYOUT_S : 1'b1;
    assign HREADYOUT_P2 = (data_sel_q == 2'd2) ? HREADYOUT_S : 1'b1;

    assign HRESP_P0 = (data_sel_q == 2'd0) ? HRESP_S : RESP_OK;
    assign HRESP_P1 = (data_sel_q == 2'd1) ? HRESP_S : RESP_OK;
    assign HRESP_P2 = (data_sel_q == 2'd2) ? HRESP_S : RESP_OK;

    assign HRDATA_P0 = HRDATA_S;
    assign HRDATA_P1 = HRDATA_S;
    assign HRDATA_P2 = HRDATA_S;
endmodule
